cluster_periph_router: RTL and testbench

//  Parametrised successor to the fixed cluster-peripheral plug wiring: one peripheral-bus slave port fanned out to
//  NB_TARGETS peripheral masters by address rule, with outstanding-transaction tracking and in-order responses.

---
 rtl/cluster_periph_router_pkg.sv | 12 +
 rtl/cluster_periph_router_id_fifo.sv | 46 ++++
 rtl/cluster_periph_router.sv | 206 ++++++++++++++++++++
 tb/tb_cluster_periph_router.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_periph_router_pkg.sv
// Shared types and constants for the cluster peripheral router.
// Address rules are {base, mask} pairs, with base in the upper 32 bits.
package cluster_periph_router_pkg;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
    } addr_rule_t;

    localparam logic [31:0] PERIPH_ERR_RDATA = 32'hDEADB33F;

endpackage

// File: rtl/cluster_periph_router_id_fifo.sv
// Id FIFO for the cluster peripheral router: holds the ids of in-flight transactions.
// A push and a pop in the same cycle are both accepted, including when the FIFO is full.
module cluster_periph_id_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (r_wptr == r_rptr);
    assign full_o    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign head_o    = r_mem[r_rptr[AW-1:0]];
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/cluster_periph_router.sv
// Peripheral-bus router: one slave port fanned out to NB_TARGETS masters, in-order responses.
// Optional watchdog/flush enabled by defining CLUSTER_PERIPH_ROUTER_TIMEOUT_EN.
module cluster_periph_router
    import cluster_periph_router_pkg::*;
#(
    parameter int NB_TARGETS      = 4,
    parameter int ID_WIDTH        = 9,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NB_TARGETS*64-1:0]       addr_rule_i,
    input  logic                           slv_req_i,
    input  logic [31:0]                    slv_add_i,
    input  logic                           slv_wen_i,
    input  logic [31:0]                    slv_wdata_i,
    input  logic [3:0]                     slv_be_i,
    input  logic [ID_WIDTH-1:0]            slv_id_i,
    output logic                           slv_gnt_o,
    output logic                           slv_r_valid_o,
    output logic                           slv_r_opc_o,
    output logic [ID_WIDTH-1:0]            slv_r_id_o,
    output logic [31:0]                    slv_r_rdata_o,
    output logic [NB_TARGETS-1:0]          mst_req_o,
    output logic [31:0]                    mst_add_o,
    output logic                           mst_wen_o,
    output logic [31:0]                    mst_wdata_o,
    output logic [3:0]                     mst_be_o,
    output logic [ID_WIDTH-1:0]            mst_id_o,
    input  logic [NB_TARGETS-1:0]          mst_gnt_i,
    input  logic [NB_TARGETS-1:0]          mst_r_valid_i,
    input  logic [NB_TARGETS-1:0]          mst_r_opc_i,
    input  logic [NB_TARGETS*ID_WIDTH-1:0] mst_r_id_i,
    input  logic [NB_TARGETS*32-1:0]       mst_r_rdata_i,
    input  logic                           clr_status_i,
    output logic                           spurious_rsp_o,
    output logic                           timeout_o
);

    localparam int TW = $clog2(NB_TARGETS + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TW-1:0] ERR_TGT = TW'(NB_TARGETS);

    logic [TW-1:0]       r_cur_tgt;
    logic [CW-1:0]       r_cnt;
    logic                r_err_valid;
    logic                r_spurious;
    logic [TW-1:0]       w_sel;
    logic                w_sel_err;
    logic                w_tgt_gnt;
    logic                w_can_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_cur_valid;
    logic                w_cur_opc;
    logic [ID_WIDTH-1:0] w_cur_id;
    logic [31:0]         w_cur_rdata;
    logic                w_other_valid;
    logic                w_live;
    logic                w_fwd;
    logic                w_spurious_set;
    logic                w_flushing;
    logic                w_flush_rsp;
    logic [ID_WIDTH-1:0] w_head;
    logic                w_empty;
    logic                w_full;

    // Lowest matching rule wins, so scan from the top down.
    always_comb begin
        addr_rule_t rule;
        w_sel = ERR_TGT;
        for (int t = NB_TARGETS - 1; t >= 0; t--) begin
            rule = addr_rule_i[t*64 +: 64];
            if ((slv_add_i & rule.mask) == rule.base) w_sel = TW'(t);
        end
    end

    assign w_sel_err = (w_sel == ERR_TGT);

    always_comb begin
        w_tgt_gnt = w_sel_err;
        mst_req_o = '0;
        for (int t = 0; t < NB_TARGETS; t++) begin
            if (w_sel == TW'(t)) begin
                w_tgt_gnt    = mst_gnt_i[t];
                mst_req_o[t] = slv_req_i && w_can_issue;
            end
        end
    end

    // The FIFO is full exactly when cnt == MAX_OUTSTANDING.
    assign w_can_issue = ((r_cnt == '0) || ((w_sel == r_cur_tgt) && !w_full)) && !w_flushing;
    assign w_push      = slv_req_i && w_can_issue && w_tgt_gnt;
    assign slv_gnt_o   = w_push;

    assign mst_add_o   = slv_add_i;
    assign mst_wen_o   = slv_wen_i;
    assign mst_wdata_o = slv_wdata_i;
    assign mst_be_o    = slv_be_i;
    assign mst_id_o    = slv_id_i;

    always_comb begin
        w_cur_valid   = 1'b0;
        w_cur_opc     = 1'b0;
        w_cur_id      = '0;
        w_cur_rdata   = '0;
        w_other_valid = 1'b0;
        for (int t = 0; t < NB_TARGETS; t++) begin
            if (r_cur_tgt == TW'(t)) begin
                w_cur_valid = mst_r_valid_i[t];
                w_cur_opc   = mst_r_opc_i[t];
                w_cur_id    = mst_r_id_i[t*ID_WIDTH +: ID_WIDTH];
                w_cur_rdata = mst_r_rdata_i[t*32 +: 32];
            end else if (mst_r_valid_i[t]) begin
                w_other_valid = 1'b1;
            end
        end
    end

    // A response with the wrong id still retires the head entry.
    assign w_live         = (r_cnt != '0) && !w_flushing;
    assign w_fwd          = w_cur_valid && w_live && (w_cur_id == w_head);
    assign w_spurious_set = w_other_valid || (w_cur_valid && !w_fwd);
    assign w_flush_rsp    = w_flushing && !w_empty && !r_err_valid;
    assign w_pop          = (w_cur_valid && w_live) || r_err_valid || w_flush_rsp;

    always_comb begin
        slv_r_valid_o = w_fwd || r_err_valid || w_flush_rsp;
        slv_r_opc_o   = 1'b0;
        slv_r_id_o    = '0;
        slv_r_rdata_o = '0;
        if (w_fwd) begin
            slv_r_opc_o   = w_cur_opc;
            slv_r_id_o    = w_cur_id;
            slv_r_rdata_o = w_cur_rdata;
        end else if (r_err_valid || w_flush_rsp) begin
            slv_r_opc_o   = 1'b1;
            slv_r_id_o    = w_head;
            slv_r_rdata_o = PERIPH_ERR_RDATA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_cur_tgt   <= '0;
            r_err_valid <= 1'b0;
            r_spurious  <= 1'b0;
        end else begin
            if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
            if (w_push) r_cur_tgt <= w_sel;
            r_err_valid <= w_push && w_sel_err;
            if (w_spurious_set)    r_spurious <= 1'b1;
            else if (clr_status_i) r_spurious <= 1'b0;
        end
    end

    assign spurious_rsp_o = r_spurious;

`ifdef CLUSTER_PERIPH_ROUTER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] r_wdog;
    logic          r_flushing;
    logic          w_wdog_run;
    logic          w_expire;

    // Down-counter reloaded whenever the target makes progress or nothing is pending.
    assign w_wdog_run = (r_cnt != '0) && !r_flushing && !w_pop;
    assign w_expire   = w_wdog_run && (r_wdog == WW'(1));
    assign w_flushing = r_flushing;
    assign timeout_o  = w_expire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wdog     <= WW'(TIMEOUT_CYCLES);
            r_flushing <= 1'b0;
        end else begin
            if (!w_wdog_run || w_expire) r_wdog <= WW'(TIMEOUT_CYCLES);
            else                         r_wdog <= r_wdog - WW'(1);
            if (w_expire)                                        r_flushing <= 1'b1;
            else if (r_flushing && w_pop && (r_cnt == CW'(1)))   r_flushing <= 1'b0;
        end
    end
`else
    assign w_flushing = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    cluster_periph_id_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (slv_id_i),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

endmodule

// File: tb/tb_cluster_periph_router.sv
// Bench for cluster_periph_router: directed sequences with a response scoreboard.
// The watchdog sequence runs only when CLUSTER_PERIPH_ROUTER_TIMEOUT_EN is defined.
module tb_cluster_periph_router;

    localparam int NT = 4;
    localparam int IW = 9;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   rdata;
        logic          opc;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NT*64-1:0] addr_rule_i;
    logic             slv_req_i;
    logic [31:0]      slv_add_i;
    logic             slv_wen_i;
    logic [31:0]      slv_wdata_i;
    logic [3:0]       slv_be_i;
    logic [IW-1:0]    slv_id_i;
    logic             slv_gnt_o;
    logic             slv_r_valid_o;
    logic             slv_r_opc_o;
    logic [IW-1:0]    slv_r_id_o;
    logic [31:0]      slv_r_rdata_o;
    logic [NT-1:0]    mst_req_o;
    logic [31:0]      mst_add_o;
    logic             mst_wen_o;
    logic [31:0]      mst_wdata_o;
    logic [3:0]       mst_be_o;
    logic [IW-1:0]    mst_id_o;
    logic [NT-1:0]    mst_gnt_i;
    logic [NT-1:0]    mst_r_valid_i;
    logic [NT-1:0]    mst_r_opc_i;
    logic [NT*IW-1:0] mst_r_id_i;
    logic [NT*32-1:0] mst_r_rdata_i;
    logic             clr_status_i;
    logic             spurious_rsp_o;
    logic             timeout_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_no   = 0;
    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_no <= cyc_no + 1;

    cluster_periph_router #(
        .NB_TARGETS(NT), .ID_WIDTH(IW), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_rule_i(addr_rule_i),
        .slv_req_i(slv_req_i), .slv_add_i(slv_add_i), .slv_wen_i(slv_wen_i),
        .slv_wdata_i(slv_wdata_i), .slv_be_i(slv_be_i), .slv_id_i(slv_id_i),
        .slv_gnt_o(slv_gnt_o), .slv_r_valid_o(slv_r_valid_o), .slv_r_opc_o(slv_r_opc_o),
        .slv_r_id_o(slv_r_id_o), .slv_r_rdata_o(slv_r_rdata_o),
        .mst_req_o(mst_req_o), .mst_add_o(mst_add_o), .mst_wen_o(mst_wen_o),
        .mst_wdata_o(mst_wdata_o), .mst_be_o(mst_be_o), .mst_id_o(mst_id_o),
        .mst_gnt_i(mst_gnt_i), .mst_r_valid_i(mst_r_valid_i), .mst_r_opc_i(mst_r_opc_i),
        .mst_r_id_i(mst_r_id_i), .mst_r_rdata_i(mst_r_rdata_i),
        .clr_status_i(clr_status_i), .spurious_rsp_o(spurious_rsp_o), .timeout_o(timeout_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response seen on the slave port must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && slv_r_valid_o) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 64'(slv_r_id_o), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rsp_id", 64'(slv_r_id_o), 64'(e.id));
                check_eq("rsp_rdata", 64'(slv_r_rdata_o), 64'(e.rdata));
                check_eq("rsp_opc", 64'(slv_r_opc_o), 64'(e.opc));
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic [31:0] addr, input logic [IW-1:0] id);
        slv_req_i   = 1'b1;
        slv_add_i   = addr;
        slv_id_i    = id;
        slv_wen_i   = 1'b1;
        slv_wdata_i = {23'd0, id};
        slv_be_i    = 4'hF;
        #1;
    endtask

    task automatic rsp(input int t, input logic [IW-1:0] id, input logic [31:0] rdata, input logic expect_fwd);
        exp_t e;
        mst_r_valid_i[t]            = 1'b1;
        mst_r_opc_i[t]              = 1'b0;
        mst_r_id_i[t*IW +: IW]      = id;
        mst_r_rdata_i[t*32 +: 32]   = rdata;
        if (expect_fwd) begin
            e.id = id; e.rdata = rdata; e.opc = 1'b0;
            sb_q.push_back(e);
        end
        #1;
    endtask

    task automatic push_err(input logic [IW-1:0] id);
        exp_t e;
        e.id = id; e.rdata = 32'hDEADB33F; e.opc = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        slv_req_i     = 1'b0;
        mst_r_valid_i = '0;
        clr_status_i  = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        addr_rule_i   = {32'h4000_0000, 32'hFFFF_0000,
                         32'h3000_0000, 32'hFFFF_0000,
                         32'h1020_0400, 32'hFFFF_FC00,
                         32'h1020_0000, 32'hFFFF_FC00};
        slv_add_i     = '0; slv_wen_i = 1'b0; slv_wdata_i = '0; slv_be_i = '0; slv_id_i = '0;
        mst_gnt_i     = '1; mst_r_opc_i = '0; mst_r_id_i = '0; mst_r_rdata_i = '0;
        idle();
        cyc(); cyc();
        rst_i = 1'b0;
        #1;
        check_eq("rst_gnt", 64'(slv_gnt_o), 64'd0);
        check_eq("rst_rvalid", 64'(slv_r_valid_o), 64'd0);
        check_eq("rst_spur", 64'(spurious_rsp_o), 64'd0);
        check_eq("rst_tmo", 64'(timeout_o), 64'd0);

        // Decode to t1 and same-cycle forwarding
        cyc(); req(32'h1020_0404, 9'd7);
        check_eq("t1_req", 64'(mst_req_o), 64'b0010);
        check_eq("t1_gnt", 64'(slv_gnt_o), 64'd1);
        check_eq("t1_bcast_add", 64'(mst_add_o), 64'h1020_0404);
        cyc(); idle(); rsp(1, 9'd7, 32'hCAFE_0001, 1'b1);
        check_eq("t1_fwd_valid", 64'(slv_r_valid_o), 64'd1);

        // Unmapped address answered by the error target one cycle later
        cyc(); idle(); req(32'h1020_0800, 9'd5);
        check_eq("err_gnt", 64'(slv_gnt_o), 64'd1);
        check_eq("err_no_mst_req", 64'(mst_req_o), 64'd0);
        push_err(9'd5);
        cyc(); idle(); #1;
        check_eq("err_rvalid", 64'(slv_r_valid_o), 64'd1);

        // Fill to MAX_OUTSTANDING on t0, then check back-pressure and in-order drain
        for (int i = 0; i < 4; i++) begin
            cyc(); req(32'h1020_0010, IW'(10 + i));
            check_eq("fill_gnt", 64'(slv_gnt_o), 64'd1);
        end
        cyc(); req(32'h1020_0010, 9'd20);
        check_eq("full_gnt", 64'(slv_gnt_o), 64'd0);
        check_eq("full_req", 64'(mst_req_o), 64'd0);
        req(32'h1020_0404, 9'd21);
        check_eq("switch_gnt", 64'(slv_gnt_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(); mst_r_valid_i = '0; rsp(0, IW'(10 + i), 32'hA000 + 32'(i), 1'b1);
            check_eq("drain_stall", 64'(slv_gnt_o), 64'd0);
        end
        cyc(); mst_r_valid_i = '0; #1;
        check_eq("switch_gnt_after", 64'(slv_gnt_o), 64'd1);
        check_eq("switch_req_after", 64'(mst_req_o), 64'b0010);
        cyc(); idle(); rsp(1, 9'd21, 32'h0000_00B0, 1'b1);

        // Response from a non-current target is dropped and flagged
        cyc(); idle(); req(32'h1020_0000, 9'd30);
        cyc(); idle(); rsp(1, 9'd30, 32'h1111, 1'b0);
        check_eq("spur_not_fwd", 64'(slv_r_valid_o), 64'd0);
        cyc(); idle(); #1;
        check_eq("spur_set", 64'(spurious_rsp_o), 64'd1);
        clr_status_i = 1'b1;
        cyc(); idle(); #1;
        check_eq("spur_clr", 64'(spurious_rsp_o), 64'd0);
        rsp(0, 9'd30, 32'h3030, 1'b1);

        // Wrong id: dropped, flagged, and the entry still retires
        cyc(); idle(); req(32'h1020_0000, 9'd40);
        cyc(); idle(); rsp(0, 9'd41, 32'h4141, 1'b0);
        check_eq("idmis_not_fwd", 64'(slv_r_valid_o), 64'd0);
        cyc(); idle(); #1;
        check_eq("idmis_spur", 64'(spurious_rsp_o), 64'd1);
        req(32'h1020_0404, 9'd42);
        check_eq("idmis_popped_gnt", 64'(slv_gnt_o), 64'd1);
        cyc(); idle(); rsp(1, 9'd42, 32'h4242, 1'b1);

        // Set beats clear in the same cycle (cnt==0, so any valid is spurious)
        cyc(); idle(); clr_status_i = 1'b1; rsp(2, 9'd0, 32'h0, 1'b0);
        cyc(); idle(); #1;
        check_eq("set_wins", 64'(spurious_rsp_o), 64'd1);
        clr_status_i = 1'b1;
        cyc(); idle(); #1;
        check_eq("clr_again", 64'(spurious_rsp_o), 64'd0);

        // Back-to-back error requests, one per cycle
        for (int i = 0; i < 3; i++) begin
            cyc(); req(32'h5000_0000, IW'(50 + i));
            check_eq("b2b_err_gnt", 64'(slv_gnt_o), 64'd1);
            push_err(IW'(50 + i));
            if (i > 0) check_eq("b2b_err_rvalid", 64'(slv_r_valid_o), 64'd1);
        end
        cyc(); idle(); #1;
        check_eq("b2b_err_last", 64'(slv_r_valid_o), 64'd1);

`ifdef CLUSTER_PERIPH_ROUTER_TIMEOUT_EN
        begin
            int c0;
            int seen;
            cyc(); req(32'h1020_0000, 9'd60);
            c0 = cyc_no;
            cyc(); req(32'h1020_0000, 9'd61);
            cyc(); idle(); #1;
            seen = 0;
            for (int k = 0; k < 40 && seen == 0; k++) begin
                if (timeout_o) begin
                    seen = 1;
                    check_eq("tmo_cycle", 64'(cyc_no - c0), 64'd16);
                    push_err(9'd60);
                    push_err(9'd61);
                end else begin
                    cyc();
                end
            end
            check_eq("tmo_seen", 64'(seen), 64'd1);
            cyc(); #1;
            check_eq("tmo_pulse", 64'(timeout_o), 64'd0);
            check_eq("flush_rsp1", 64'(slv_r_valid_o), 64'd1);
            cyc(); cyc(); rsp(0, 9'd60, 32'h6060, 1'b0);
            check_eq("late_not_fwd", 64'(slv_r_valid_o), 64'd0);
            cyc(); idle(); #1;
            check_eq("late_spur", 64'(spurious_rsp_o), 64'd1);
            clr_status_i = 1'b1;
            cyc(); idle();
        end
`endif

        // Reset with three in flight discards everything
        for (int i = 0; i < 3; i++) begin
            cyc(); req(32'h1020_0000, IW'(70 + i));
        end
        cyc(); idle(); rsp(2, 9'd0, 32'h0, 1'b0);
        cyc(); idle(); rst_i = 1'b1;
        cyc(); rst_i = 1'b0; #1;
        check_eq("mid_rst_gnt", 64'(slv_gnt_o), 64'd0);
        check_eq("mid_rst_req", 64'(mst_req_o), 64'd0);
        check_eq("mid_rst_rvalid", 64'(slv_r_valid_o), 64'd0);
        check_eq("mid_rst_spur", 64'(spurious_rsp_o), 64'd0);
        req(32'h1020_0404, 9'd73);
        check_eq("post_rst_gnt", 64'(slv_gnt_o), 64'd1);
        cyc(); idle(); rsp(1, 9'd73, 32'h7373, 1'b1);
        cyc(); idle(); rsp(0, 9'd70, 32'h7070, 1'b0);
        check_eq("post_rst_late", 64'(slv_r_valid_o), 64'd0);
        cyc(); idle(); #1;
        check_eq("post_rst_spur", 64'(spurious_rsp_o), 64'd1);

        cyc(); cyc();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
